// File: rtl/wishbone_slave.sv
// Wishbone-classic slave: 16 x 32-bit register file with registered acknowledge
// and a sticky lock that engages when 32'hCAFEBABE is written to any register.
module wishbone_slave (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  adr,
  input  logic [31:0] dat_mosi,
  output logic [31:0] dat_miso,
  input  logic        we,
  input  logic        cyc,
  input  logic        stb,
  output logic        ack
);

  localparam logic [31:0] LOCK_PATTERN = 32'hCAFEBABE;

  logic [31:0] regs_q [16];
  logic [31:0] regs_d [16];
  logic [31:0] dat_miso_q, dat_miso_d;
  logic        ack_q, ack_d;
  logic        locked_q, locked_d;
  logic        accept;

  // The ack term keeps a held request from being accepted twice in a row.
  assign accept = cyc & stb & ~ack_q & ~locked_q;

  always_comb begin
    regs_d     = regs_q;
    dat_miso_d = dat_miso_q;
    ack_d      = 1'b0;
    locked_d   = locked_q;
    if (locked_q) begin
      dat_miso_d = '0;
    end else if (accept) begin
      ack_d = 1'b1;
      if (we) begin
        regs_d[adr] = dat_mosi;
        if (dat_mosi == LOCK_PATTERN) begin
          locked_d   = 1'b1;
          dat_miso_d = '0;
        end
      end else begin
        dat_miso_d = regs_q[adr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
      dat_miso_q <= '0;
      ack_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      dat_miso_q <= dat_miso_d;
      ack_q      <= ack_d;
      locked_q   <= locked_d;
    end
  end

  assign dat_miso = dat_miso_q;
  assign ack      = ack_q;

endmodule

// File: tb/tb_wishbone_slave.sv
// Self-checking bench for wishbone_slave: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a bus-level model.
module tb_wishbone_slave;

  logic        clk;
  logic        rst;
  logic [3:0]  adr;
  logic [31:0] dat_mosi;
  logic [31:0] dat_miso;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;

  int n_checks = 0;
  int n_errors = 0;

  wishbone_slave dut (
    .clk      (clk),
    .rst      (rst),
    .adr      (adr),
    .dat_mosi (dat_mosi),
    .dat_miso (dat_miso),
    .we       (we),
    .cyc      (cyc),
    .stb      (stb),
    .ack      (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus-level model: a memory, the last read word, a pending-ack flag and a lock.
  logic [31:0] m_regs [16];
  logic [31:0] m_dat;
  logic        m_ack;
  logic        m_locked;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] <= '0;
      m_dat    <= '0;
      m_ack    <= 1'b0;
      m_locked <= 1'b0;
    end else if (m_locked) begin
      m_ack <= 1'b0;
      m_dat <= '0;
    end else if (cyc && stb && !m_ack) begin
      m_ack <= 1'b1;
      if (we) begin
        m_regs[adr] <= dat_mosi;
        if (dat_mosi == 32'hCAFEBABE) begin
          m_locked <= 1'b1;
          m_dat    <= '0;
        end
      end else begin
        m_dat <= m_regs[adr];
      end
    end else begin
      m_ack <= 1'b0;
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if (ack !== m_ack || dat_miso !== m_dat) begin
      n_errors++;
      $display("[TB] FAIL model_cycle t=%0t: ack=%b dat_miso=%08h, required ack=%b dat_miso=%08h",
               $time, ack, dat_miso, m_ack, m_dat);
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_checks++;
    if (actual !== required) begin
      n_errors++;
      $display("[TB] FAIL %s: got %08h, required %08h", name, actual, required);
    end
  endtask

  // Issues one transfer from a falling edge and waits a bounded number of cycles for ack.
  task automatic apply_stimulus(input logic w, input logic [3:0] a, input logic [31:0] d,
                                input logic expect_ack, output logic [31:0] rdata);
    logic got;
    got   = 1'b0;
    rdata = '0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_mosi = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rdata = dat_miso;
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check_output(w ? "write_ack" : "read_ack", {31'b0, got}, {31'b0, expect_ack});
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic [5:0]  ack_seq;
  int          locked_cycles;

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_mosi = '0;
    repeat (3) @(negedge clk);
    check_output("reset_ack", {31'b0, ack}, 32'd0);
    check_output("reset_dat", dat_miso, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    apply_stimulus(1'b1, 4'd1, 32'hDEADBEEF, 1'b1, rd);
    apply_stimulus(1'b0, 4'd1, 32'h0, 1'b1, rd);
    check_output("read_adr1", rd, 32'hDEADBEEF);

    apply_stimulus(1'b1, 4'd0, 32'h11111111, 1'b1, rd);
    apply_stimulus(1'b1, 4'd15, 32'h22222222, 1'b1, rd);
    apply_stimulus(1'b0, 4'd0, 32'h0, 1'b1, rd);
    check_output("read_adr0", rd, 32'h11111111);
    apply_stimulus(1'b0, 4'd15, 32'h0, 1'b1, rd);
    check_output("read_adr15", rd, 32'h22222222);

    // Held request: first sample precedes the accepting edge.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd1;
    ack_seq[5] = ack;
    for (int i = 4; i >= 0; i--) begin
      @(negedge clk);
      ack_seq[i] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    check_output("held_ack_seq", {26'b0, ack_seq}, 32'h15);
    check_output("held_read_dat", dat_miso, 32'hDEADBEEF);
    @(negedge clk);

    apply_stimulus(1'b1, 4'd2, 32'hCAFEBABE, 1'b1, rd);
    check_output("lock_dat_zero", dat_miso, 32'd0);
    apply_stimulus(1'b0, 4'd2, 32'h0, 1'b0, rd);
    check_output("locked_read_dat", rd, 32'd0);
    apply_stimulus(1'b1, 4'd3, 32'h12345678, 1'b0, rd);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(1'b0, 4'd3, 32'h0, 1'b1, rd);
    check_output("post_reset_adr3", rd, 32'd0);
    apply_stimulus(1'b1, 4'd4, 32'hA5A5A5A5, 1'b1, rd);
    apply_stimulus(1'b0, 4'd4, 32'h0, 1'b1, rd);
    check_output("post_reset_adr4", rd, 32'hA5A5A5A5);

    // Reset asserted while an acknowledge is being driven.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'd5; dat_mosi = 32'h55AA55AA;
    @(posedge clk);
    #2;
    check_output("pending_ack_high", {31'b0, ack}, 32'd1);
    rst = 1'b1;
    #1;
    check_output("async_ack_drop", {31'b0, ack}, 32'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b0, 4'(i), 32'h0, 1'b1, rd);
      check_output($sformatf("cleared_reg%0d", i), rd, 32'd0);
    end

    // Randomized traffic; the per-cycle compare carries the checking here.
    locked_cycles = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc      = ($urandom_range(0, 9) < 7);
      stb      = ($urandom_range(0, 9) < 7);
      we       = $urandom_range(0, 1);
      adr      = 4'($urandom_range(0, 15));
      dat_mosi = ($urandom_range(0, 149) == 0) ? 32'hCAFEBABE : $urandom;
      if (m_locked) locked_cycles++;
      if (locked_cycles > 25 || $urandom_range(0, 299) == 0) begin
        locked_cycles = 0;
        #3 rst = 1'b1;
        #4 rst = 1'b0;
      end
      @(negedge clk);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
